// File: rtl/segn_display.sv
// Multiplexed common-anode 7-segment driver: hex or double-dabble decimal display,
// leading-zero blanking, per-digit decimal points, overflow dashes, prescaled scan.
module segn_display #(
   parameter int DIGITS  = 4,
   parameter int CLK_DIV = 40000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [4*DIGITS-1:0] value,
   input  logic                load,
   input  logic                dec_mode,
   input  logic                blank_lz,
   input  logic [DIGITS-1:0]   dp,
   output logic                busy,
   output logic [DIGITS-1:0]   an,
   output logic [7:0]          cat
);

   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(W + 1);
   localparam int PW = $clog2(CLK_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   function automatic longint pow10(input int n);
      longint r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   localparam logic [W-1:0] LIMIT = W'(pow10(DIGITS) - 64'd1);

   function automatic logic [7:0] hex_glyph(input logic [3:0] n);
      logic [7:0] g;
      case (n)
         4'h0: g = 8'hC0;
         4'h1: g = 8'hF9;
         4'h2: g = 8'hA4;
         4'h3: g = 8'hB0;
         4'h4: g = 8'h99;
         4'h5: g = 8'h92;
         4'h6: g = 8'h82;
         4'h7: g = 8'hF8;
         4'h8: g = 8'h80;
         4'h9: g = 8'h90;
         4'hA: g = 8'h88;
         4'hB: g = 8'h83;
         4'hC: g = 8'hC6;
         4'hD: g = 8'hA1;
         4'hE: g = 8'h86;
         default: g = 8'h8E;
      endcase
      return g;
   endfunction

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

   state_t              state_reg, state_next;
   logic                busy_reg;
   logic [W-1:0]        bin_reg, bcd_reg, bcd_adj;
   logic [CW-1:0]       iter_reg;
   logic                cap_ovf_reg, cap_blank_reg;
   logic [DIGITS-1:0]   cap_dp_reg;
   logic [W-1:0]        disp_reg;
   logic                show_ovf_reg, show_blank_reg;
   logic [DIGITS-1:0]   show_dp_reg;
   logic [PW-1:0]       presc_reg;
   logic [IW-1:0]       idx_reg;
   logic [DIGITS-1:0]   an_reg;
   logic [7:0]          cat_reg;

   logic                start_conv, load_hex, shift_en, commit, tick;
   logic [7:0]          seg_digit [DIGITS];
   logic                zrun;
   logic [3:0]          nib;
   logic [7:0]          g;
   logic                msb_unused;

   // Double-dabble add-3 correction, one nibble per digit
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                     bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
      end
   endgenerate

   // Top bit is shifted out; an in-range value never sets it
   assign msb_unused = bcd_adj[W-1];

   always_comb begin
      state_next = state_reg;
      start_conv = 1'b0;
      load_hex   = 1'b0;
      shift_en   = 1'b0;
      commit     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (load) begin
               if (dec_mode) begin
                  start_conv = 1'b1;
                  state_next = CONV;
               end else begin
                  load_hex = 1'b1;
               end
            end
         end
         CONV: begin
            shift_en = 1'b1;
            if (iter_reg == CW'(W - 1)) state_next = COMMIT;
         end
         COMMIT: begin
            commit     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         busy_reg       <= 1'b0;
         bin_reg        <= '0;
         bcd_reg        <= '0;
         iter_reg       <= '0;
         cap_ovf_reg    <= 1'b0;
         cap_blank_reg  <= 1'b0;
         cap_dp_reg     <= '0;
         disp_reg       <= '0;
         show_ovf_reg   <= 1'b0;
         show_blank_reg <= 1'b0;
         show_dp_reg    <= '0;
      end else begin
         state_reg <= state_next;
         busy_reg  <= (state_next != IDLE);
         if (load_hex) begin
            cap_ovf_reg    <= 1'b0;
            cap_blank_reg  <= blank_lz;
            cap_dp_reg     <= dp;
            disp_reg       <= value;
            show_ovf_reg   <= 1'b0;
            show_blank_reg <= blank_lz;
            show_dp_reg    <= dp;
         end else if (start_conv) begin
            bin_reg       <= value;
            bcd_reg       <= '0;
            iter_reg      <= '0;
            cap_ovf_reg   <= (value > LIMIT);
            cap_blank_reg <= blank_lz;
            cap_dp_reg    <= dp;
         end else if (shift_en) begin
            bcd_reg  <= {bcd_adj[W-2:0], bin_reg[W-1]};
            bin_reg  <= {bin_reg[W-2:0], 1'b0};
            iter_reg <= iter_reg + 1'b1;
         end else if (commit) begin
            disp_reg       <= bcd_reg;
            show_ovf_reg   <= cap_ovf_reg;
            show_blank_reg <= cap_blank_reg;
            show_dp_reg    <= cap_dp_reg;
         end
      end
   end

   // Glyph per digit; zrun tracks the unbroken run of zeros from the top digit
   always_comb begin
      zrun = 1'b1;
      nib  = 4'h0;
      g    = 8'hFF;
      for (int i = 0; i < DIGITS; i++) seg_digit[i] = 8'hFF;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nib  = disp_reg[4*i +: 4];
         zrun = zrun && (nib == 4'h0);
         g    = hex_glyph(nib);
         if (show_ovf_reg)
            g = 8'hBF;
         else if (show_blank_reg && zrun && (i != 0))
            g = 8'hFF;
         if (show_dp_reg[i]) g[7] = 1'b0;
         seg_digit[i] = g;
      end
   end

   // Tick fires on the edge where the prescaler lands on CLK_DIV-1
   assign tick = (presc_reg == PW'(CLK_DIV - 2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_reg <= '0;
         idx_reg   <= '0;
         an_reg    <= '1;
         cat_reg   <= 8'hFF;
      end else begin
         presc_reg <= (presc_reg == PW'(CLK_DIV - 1)) ? '0 : presc_reg + 1'b1;
         if (tick) begin
            an_reg  <= ~(DIGITS'(1) << idx_reg);
            cat_reg <= seg_digit[idx_reg];
            idx_reg <= (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
         end
      end
   end

   assign busy = busy_reg;
   assign an   = an_reg;
   assign cat  = cat_reg;

endmodule

// File: doc/segn_display.md
# segn_display

Parametrised multiplexed 7-segment display driver for the board top level, successor to the fixed 4-digit scan driver. It scans DIGITS common-anode digits from the system clock using an internal clock-enable prescaler, so no derived display clock is needed. Values are loaded through a load/busy handshake. Each load is shown either as hexadecimal or as decimal; decimal mode uses a sequential binary-to-BCD converter. The driver also supports optional leading-zero blanking, per-digit decimal points and an overflow indication.

## Interface
- DIGITS, 4, number of digits (1..8); value width W = 4*DIGITS
- CLK_DIV, 40000, system clocks per digit-scan step (>= 2)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- value  in  W  binary value to display
- load  in  1  load request, sampled only when busy = 0
- dec_mode  in  1  1 = decimal, 0 = hex; captured with load
- blank_lz  in  1  1 = blank leading zeros; captured with load
- dp  in  DIGITS  decimal-point enables, bit i = digit i; captured with load
- busy  out  1  conversion in progress; loads ignored
- an  out  DIGITS  digit enables, active-low, bit 0 = least-significant digit
- cat  out  8  segments, active-low; cat[0..6] = a..g, cat[7] = dp

## Operation
- Load handling:
  - A load with busy = 0 captures value, dec_mode, blank_lz and dp.
  - A load with busy = 1 is ignored. No queueing.
- FSM states: IDLE, CONV, COMMIT.
- Hex load:
  - Stays in IDLE.
  - The nibbles of value go to the display register on the same edge.
  - busy is never asserted.
- Decimal load:
  - IDLE -> CONV. Runs double-dabble: W shift iterations, one per clock, over DIGITS BCD digits.
  - CONV -> COMMIT after W iterations. COMMIT writes the BCD result to the display register, then returns to IDLE.
- Overflow, decimal mode only:
  - The flag is set at load when value > 10^DIGITS - 1. The limit is a localparam computed from DIGITS.
  - On commit with overflow set, every digit shows a dash (g only).
- Leading-zero blanking:
  - Applies when the captured blank_lz = 1 and overflow is clear.
  - Zero digits from DIGITS-1 downward, up to the first nonzero digit, are blank.
  - Digit 0 is never blanked.
- dp:
  - The captured dp bit is ORed onto every digit: normal, dash or blank.
- Glyphs: standard 0-9, A, b, C, d, E, F.
  - Examples: 0 = C0, 1 = F9, 8 = 80, F = 8E.
  - dash = BF, blank = FF. All values are hex and assume dp off.
- Scan:
  - The prescaler counts 0..CLK_DIV-1 and wraps.
  - A tick is issued on the count CLK_DIV-1.
  - On each tick, an and cat are registered for digit index idx, with an = ~(1 << idx); then idx increments and wraps DIGITS-1 -> 0.
  - Scanning runs continuously and independently of the FSM.
  - The digit currently shown updates on its next tick after a commit.

## Timing
- Reset (asynchronous, immediate) gives:
  - an = all ones, cat = FF, busy = 0
  - FSM = IDLE, display register = 0, captured flags = 0
  - prescaler = 0, idx = 0
- Reset during CONV or COMMIT aborts the conversion. No partial result is committed.
- First tick occurs at the edge where the prescaler reaches CLK_DIV-1. That edge shows digit 0 (an[0] = 0); each later tick moves to the next digit.
- Hex latency: display register valid 1 clock after the load edge.
- Decimal latency:
  - busy rises on the edge after the load edge.
  - busy stays high for exactly W+1 clocks (W CONV, 1 COMMIT).
  - The display register is valid on the edge on which busy falls.
- A load asserted in the same cycle that busy falls is accepted.
- Exactly one an bit is low at any time after the first tick; there is no blanking gap between digits.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset and first scan (DIGITS = 4, CLK_DIV = 4):
  - Before the first tick: an = F, cat = FF.
  - Hex load of 16'h12F0.
  - Successive ticks show an = E/D/B/7 with cat = C0/8E/A4/F9.
  - The digit sequence wraps back to E.
- Decimal load of 16'd9999:
  - busy high for 17 clocks.
  - Every digit shows cat = 90.
  - A load of 16'd5 during busy is ignored.
- Decimal load of 16'd10000:
  - Overflow.
  - All four digits show BF.
  - With dp = 4'b0001, digit 0 shows 3F.
- Leading-zero blanking:
  - Decimal load of 16'd7 with blank_lz = 1.
  - Digits 3..1 show FF, digit 0 shows F8.
  - Hex load of 0 with blank_lz = 1: digits 3..1 show FF, digit 0 shows C0.
- Reset mid-conversion:
  - Decimal load of 16'd1234, then rst_n low at CONV iteration 8.
  - busy falls immediately, display register = 0, FSM = IDLE.
  - After release, a new load completes normally.
- DIGITS = 6, CLK_DIV = 2:
  - Decimal load of 24'd999999: latency 25 clocks, six digits of 90, scan period 12 clocks.
  - Decimal load of 24'd1000000: overflow, all six digits show dashes.
